// File: rtl/led_pkg.sv
// Shared types and constants for the LED pattern generator.
package led_pkg;

  // Per-channel operating mode, encoded exactly as presented on cfg_mode.
  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_PULSE = 2'b11
  } led_mode_e;

  // Width of the free-running brightness counter (duty resolution 1/16).
  localparam int unsigned PWM_W = 4;

endpackage : led_pkg

// File: rtl/led_tick_prescaler.sv
// Divides the system clock down to a one-cycle pattern tick every TICK_DIV cycles.
module led_tick_prescaler #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk_in,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: wrap to zero after the terminal value.
  always_comb begin
    if (cnt_q == TERM) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Prescaler count register.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == TERM);

endmodule : led_tick_prescaler

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator (OFF / ON / BLINK / PULSE per channel).
// Optional brightness control is compiled in with macro LED_PATTERN_PWM_EN;
// without it cfg_duty is ignored and lit LEDs are driven steadily.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int unsigned N_CH     = 8,
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned PER_W    = 4
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [4:0]       cfg_ch,
  input  logic [1:0]       cfg_mode,
  input  logic [PER_W-1:0] cfg_period,
  input  logic [3:0]       cfg_duty,
  output logic [N_CH-1:0]  led,
  output logic [N_CH-1:0]  busy
);

  logic tick_s;
  logic wr_en_s;
  logic cfg_ready_q;
  logic cfg_ready_d;

  led_mode_e        mode_q   [N_CH];
  led_mode_e        mode_d   [N_CH];
  logic [PER_W-1:0] period_q [N_CH];
  logic [PER_W-1:0] period_d [N_CH];
  logic [PER_W-1:0] cnt_q    [N_CH];
  logic [PER_W-1:0] cnt_d    [N_CH];
  logic             phase_q  [N_CH];
  logic             phase_d  [N_CH];

  logic [N_CH-1:0] lit_s;
  logic [N_CH-1:0] busy_s;
  logic [N_CH-1:0] gate_s;
  logic [N_CH-1:0] led_q;
  logic [N_CH-1:0] busy_q;

  led_tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .tick   (tick_s)
  );

  assign wr_en_s = cfg_valid & cfg_ready_q;

  // Ready drops for exactly one cycle after each accepted write.
  always_comb begin
    if (wr_en_s) begin
      cfg_ready_d = 1'b0;
    end else begin
      cfg_ready_d = 1'b1;
    end
  end

  // Per-channel next state: a write overrides (and swallows) a coincident tick.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      mode_d[i]   = mode_q[i];
      period_d[i] = period_q[i];
      cnt_d[i]    = cnt_q[i];
      phase_d[i]  = phase_q[i];
      if (wr_en_s && (cfg_ch == 5'(i))) begin
        mode_d[i]   = led_mode_e'(cfg_mode);
        period_d[i] = (cfg_period == '0) ? PER_W'(1) : cfg_period;
        cnt_d[i]    = '0;
        phase_d[i]  = 1'b1;
      end else if (tick_s) begin
        case (mode_q[i])
          MODE_BLINK: begin
            if (cnt_q[i] == period_q[i] - PER_W'(1)) begin
              cnt_d[i]   = '0;
              phase_d[i] = ~phase_q[i];
            end else begin
              cnt_d[i] = cnt_q[i] + PER_W'(1);
            end
          end
          MODE_PULSE: begin
            if (cnt_q[i] == period_q[i] - PER_W'(1)) begin
              cnt_d[i]  = '0;
              mode_d[i] = MODE_OFF;
            end else begin
              cnt_d[i] = cnt_q[i] + PER_W'(1);
            end
          end
          default: begin
            cnt_d[i] = '0;
          end
        endcase
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // Channel state and handshake registers.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ready_q <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        mode_q[i]   <= MODE_OFF;
        period_q[i] <= PER_W'(1);
        cnt_q[i]    <= '0;
        phase_q[i]  <= 1'b0;
      end
    end else begin
      cfg_ready_q <= cfg_ready_d;
      for (int i = 0; i < N_CH; i++) begin
        mode_q[i]   <= mode_d[i];
        period_q[i] <= period_d[i];
        cnt_q[i]    <= cnt_d[i];
        phase_q[i]  <= phase_d[i];
      end
    end
  end

  // Decode each channel's mode into lit/busy levels.
  always_comb begin
    lit_s  = '0;
    busy_s = '0;
    for (int i = 0; i < N_CH; i++) begin
      case (mode_q[i])
        MODE_ON:    lit_s[i] = 1'b1;
        MODE_BLINK: lit_s[i] = phase_q[i];
        MODE_PULSE: begin
          lit_s[i]  = 1'b1;
          busy_s[i] = 1'b1;
        end
        default:    lit_s[i] = 1'b0;
      endcase
    end
  end

`ifdef LED_PATTERN_PWM_EN
  logic [PWM_W-1:0] pwm_q;
  logic [PWM_W-1:0] duty_q [N_CH];
  logic [PWM_W-1:0] duty_d [N_CH];

  // Duty is captured with the rest of a valid channel write.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      if (wr_en_s && (cfg_ch == 5'(i))) begin
        duty_d[i] = cfg_duty;
      end else begin
        duty_d[i] = duty_q[i];
      end
    end
  end

  // Free-running PWM counter and per-channel duty registers.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        duty_q[i] <= 4'd15;
      end
    end else begin
      pwm_q <= pwm_q + PWM_W'(1);
      for (int i = 0; i < N_CH; i++) begin
        duty_q[i] <= duty_d[i];
      end
    end
  end

  // A lit channel is on only while the PWM counter is below its duty.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      gate_s[i] = (pwm_q < duty_q[i]);
    end
  end
`else
  logic unused_duty_s;
  assign unused_duty_s = ^cfg_duty;

  // Without brightness control lit channels are driven steadily.
  always_comb begin
    gate_s = '1;
  end
`endif

  // Registered LED and busy drive.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      led_q  <= '0;
      busy_q <= '0;
    end else begin
      led_q  <= lit_s & gate_s;
      busy_q <= busy_s;
    end
  end

  assign led       = led_q;
  assign busy      = busy_q;
  assign cfg_ready = cfg_ready_q;

endmodule : led_pattern_gen

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen (TICK_DIV=4, N_CH=4, PER_W=4).
// Build with LED_PATTERN_PWM_EN defined to check the brightness variant.
module tb_led_pattern_gen;

  localparam int N_CH     = 4;
  localparam int TICK_DIV = 4;
  localparam int PER_W    = 4;

  localparam int M_OFF   = 0;
  localparam int M_ON    = 1;
  localparam int M_BLINK = 2;
  localparam int M_PULSE = 3;

  logic             clk_in = 1'b0;
  logic             rst_n;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [4:0]       cfg_ch;
  logic [1:0]       cfg_mode;
  logic [PER_W-1:0] cfg_period;
  logic [3:0]       cfg_duty;
  logic [N_CH-1:0]  led;
  logic [N_CH-1:0]  busy;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: configuration plus the edge at which it was accepted.
  int edge_cnt;
  int m_mode [N_CH];
  int m_per  [N_CH];
  int m_duty [N_CH];
  int m_acc  [N_CH];
  bit m_ready;
  logic [N_CH-1:0] exp_led;
  logic [N_CH-1:0] exp_busy;
  logic            exp_ready;

  led_pattern_gen #(
    .N_CH     (N_CH),
    .TICK_DIV (TICK_DIV),
    .PER_W    (PER_W)
  ) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_mode   (cfg_mode),
    .cfg_period (cfg_period),
    .cfg_duty   (cfg_duty),
    .led        (led),
    .busy       (busy)
  );

  always #5 clk_in = ~clk_in;

  task automatic model_reset();
    edge_cnt = 0;
    m_ready  = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      m_mode[c] = M_OFF;
      m_per[c]  = 1;
      m_duty[c] = 15;
      m_acc[c]  = 0;
    end
  endtask

  // Advance one rising edge, derive the expected outputs from the model, sample #1 later.
  // Ticks land on edges that are multiples of TICK_DIV (counted from reset release);
  // the outputs after edge E reflect state settled at edge E-1.
  task automatic step();
    int  n;
    bit  lit;
    bit  bsy;
    @(posedge clk_in);
    edge_cnt = edge_cnt + 1;
    for (int c = 0; c < N_CH; c++) begin
      n   = (edge_cnt - 1) / TICK_DIV - m_acc[c] / TICK_DIV;
      lit = 1'b0;
      bsy = 1'b0;
      case (m_mode[c])
        M_ON:    lit = 1'b1;
        M_BLINK: lit = ((n / m_per[c]) % 2) == 0;
        M_PULSE: begin
          lit = (n < m_per[c]);
          bsy = lit;
        end
        default: lit = 1'b0;
      endcase
`ifdef LED_PATTERN_PWM_EN
      if (((edge_cnt - 1) % 16) >= m_duty[c]) lit = 1'b0;
`endif
      exp_led[c]  = lit;
      exp_busy[c] = bsy;
    end
    if (cfg_valid && m_ready) begin
      if (int'(cfg_ch) < N_CH) begin
        m_mode[cfg_ch] = int'(cfg_mode);
        m_per[cfg_ch]  = (cfg_period == 0) ? 1 : int'(cfg_period);
        m_duty[cfg_ch] = int'(cfg_duty);
        m_acc[cfg_ch]  = edge_cnt;
      end
      m_ready = 1'b0;
    end else begin
      m_ready = 1'b1;
    end
    exp_ready = m_ready;
    #1;
  endtask

  task automatic drive(input int ch, input int mode, input int per, input int duty);
    cfg_valid  = 1'b1;
    cfg_ch     = 5'(ch);
    cfg_mode   = 2'(mode);
    cfg_period = PER_W'(per);
    cfg_duty   = 4'(duty);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cfg_valid = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_period = '0; cfg_duty = '0;
    model_reset();
    repeat (3) @(posedge clk_in);
    #1;
    n_cmp++;
    if ({led, busy, cfg_ready} !== {(2 * N_CH + 1){1'b0}}) begin
      n_err++;
      $display("FAIL reset_hold: led=%b busy=%b ready=%b, want all 0", led, busy, cfg_ready);
    end
    @(negedge clk_in);
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (cfg_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release_ready: got %b want 1", cfg_ready);
    end
    // Start a long pulse, then reset in the middle of it.
    drive(2, M_PULSE, 5, 15);
    step();
    cfg_valid = 1'b0;
    repeat (3) step();
    n_cmp++;
    if (busy !== exp_busy || exp_busy[2] !== 1'b1) begin
      n_err++;
      $display("FAIL pulse_before_reset: busy=%b want %b", busy, exp_busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({led, busy, cfg_ready} !== {(2 * N_CH + 1){1'b0}}) begin
      n_err++;
      $display("FAIL reset_midrun: led=%b busy=%b ready=%b, want all 0", led, busy, cfg_ready);
    end
    @(negedge clk_in);
    rst_n = 1'b1;
    model_reset();
    step();
    n_cmp++;
    if (cfg_ready !== 1'b1 || led !== 4'b0000 || busy !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_rerelease: ready=%b led=%b busy=%b want 1/0000/0000", cfg_ready, led, busy);
    end
  endtask

  task automatic test_blink();
    int tog [8];
    int ntog;
    logic prev;
    drive(1, M_BLINK, 2, 15);
    step();
    cfg_valid = 1'b0;
    step();
    n_cmp++;
    if (led !== exp_led || led[1] !== 1'b1) begin
      n_err++;
      $display("FAIL blink_start: led=%b want %b with led[1]=1", led, exp_led);
    end
    ntog = 0;
    prev = led[1];
    for (int k = 0; k < 30; k++) begin
      step();
      n_cmp++;
      if (led !== exp_led || busy !== exp_busy) begin
        n_err++;
        $display("FAIL blink_run: led=%b busy=%b want %b %b", led, busy, exp_led, exp_busy);
      end
      if (led[1] !== prev && ntog < 8) begin
        tog[ntog] = edge_cnt;
        ntog++;
      end
      prev = led[1];
    end
`ifndef LED_PATTERN_PWM_EN
    n_cmp++;
    if (ntog < 2 || (tog[1] - tog[0]) != 8) begin
      n_err++;
      $display("FAIL blink_interval: toggles=%0d interval=%0d want 8", ntog, (ntog < 2) ? 0 : tog[1] - tog[0]);
    end
`endif
  endtask

  task automatic test_pulse();
    int nbusy;
    for (int k = 0; k < TICK_DIV && (edge_cnt % TICK_DIV) != TICK_DIV - 1; k++) step();
    drive(2, M_PULSE, 3, 15);
    step();
    cfg_valid = 1'b0;
    nbusy = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      n_cmp++;
      if (led !== exp_led || busy !== exp_busy) begin
        n_err++;
        $display("FAIL pulse_run: led=%b busy=%b want %b %b", led, busy, exp_led, exp_busy);
      end
      if (busy[2] === 1'b1) nbusy++;
    end
    n_cmp++;
    if (nbusy != 12 || busy[2] !== 1'b0 || led[2] !== 1'b0) begin
      n_err++;
      $display("FAIL pulse_length: busy cycles=%0d end led2=%b busy2=%b want 12/0/0", nbusy, led[2], busy[2]);
    end
  endtask

  task automatic test_back_to_back();
    drive(0, M_ON, 1, 15);
    step();
    n_cmp++;
    if (cfg_ready !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_first: ready=%b want 0", cfg_ready);
    end
    drive(3, M_BLINK, 4, 15);
    step();
    n_cmp++;
    if (cfg_ready !== 1'b1 || led !== exp_led) begin
      n_err++;
      $display("FAIL b2b_second_refused: ready=%b led=%b want 1 %b", cfg_ready, led, exp_led);
    end
    step();
    cfg_valid = 1'b0;
    n_cmp++;
    if (cfg_ready !== 1'b0 || led !== exp_led) begin
      n_err++;
      $display("FAIL b2b_second_taken: ready=%b led=%b want 0 %b", cfg_ready, led, exp_led);
    end
    step();
    n_cmp++;
    if (cfg_ready !== 1'b1 || led !== exp_led || m_mode[3] != M_BLINK) begin
      n_err++;
      $display("FAIL b2b_settle: ready=%b led=%b want 1 %b", cfg_ready, led, exp_led);
    end
  endtask

  task automatic test_invalid_ch();
    drive(7, M_ON, 1, 15);
    step();
    cfg_valid = 1'b0;
    n_cmp++;
    if (cfg_ready !== 1'b0) begin
      n_err++;
      $display("FAIL invalid_handshake: ready=%b want 0", cfg_ready);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if (led !== exp_led || busy !== exp_busy || cfg_ready !== 1'b1) begin
        n_err++;
        $display("FAIL invalid_nochange: led=%b busy=%b ready=%b want %b %b 1", led, busy, cfg_ready, exp_led, exp_busy);
      end
    end
  endtask

  task automatic test_tick_collision();
    int ones;
    for (int k = 0; k < TICK_DIV && (edge_cnt % TICK_DIV) != TICK_DIV - 1; k++) step();
    drive(1, M_BLINK, 1, 15);
    step();
    cfg_valid = 1'b0;
    ones = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      n_cmp++;
      if (led !== exp_led) begin
        n_err++;
        $display("FAIL collision_run: led=%b want %b", led, exp_led);
      end
      if (led[1] === 1'b1) ones++;
    end
`ifndef LED_PATTERN_PWM_EN
    n_cmp++;
    if (ones != 4) begin
      n_err++;
      $display("FAIL collision_phase: led[1] high cycles=%0d want 4", ones);
    end
`endif
  endtask

  task automatic test_pwm();
    int ones;
    drive(0, M_ON, 1, 4);
    step();
    cfg_valid = 1'b0;
    step();
    ones = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      n_cmp++;
      if (led[0] !== exp_led[0]) begin
        n_err++;
        $display("FAIL pwm_run: led0=%b want %b", led[0], exp_led[0]);
      end
      if (led[0] === 1'b1) ones++;
    end
    n_cmp++;
`ifdef LED_PATTERN_PWM_EN
    if (ones != 4) begin
`else
    if (ones != 16) begin
`endif
      n_err++;
      $display("FAIL pwm_duty: led0 high cycles=%0d of 16", ones);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      cfg_valid  = ($urandom_range(0, 2) == 0);
      cfg_ch     = 5'($urandom_range(0, 5));
      cfg_mode   = 2'($urandom_range(0, 3));
      cfg_period = PER_W'($urandom_range(0, 6));
      cfg_duty   = 4'($urandom_range(0, 15));
      step();
      n_cmp++;
      if (led !== exp_led || busy !== exp_busy || cfg_ready !== exp_ready) begin
        n_err++;
        $display("FAIL random: led=%b busy=%b ready=%b want %b %b %b",
                 led, busy, cfg_ready, exp_led, exp_busy, exp_ready);
      end
    end
    cfg_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_blink();
    test_pulse();
    test_back_to_back();
    test_invalid_ch();
    test_tick_collision();
    test_pwm();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_led_pattern_gen

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 Parameter N_CH, default 8, number of independent LED channels (1..32).
REQ-002 Parameter TICK_DIV, default 50_000_000, clk_in cycles per pattern tick (>=2).
REQ-003 Parameter PER_W, default 4, width of per-channel period field.
REQ-004 Port clk_in  input  1  single system clock; all logic on its rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Port cfg_valid  input  1  configuration write request.
REQ-007 Port cfg_ready  output  1  block can accept a write this cycle.
REQ-008 Port cfg_ch  input  5  target channel index.
REQ-009 Port cfg_mode  input  2  mode: 00 OFF, 01 ON, 10 BLINK, 11 PULSE.
REQ-010 Port cfg_period  input  PER_W  ticks per phase.
REQ-011 Port cfg_duty  input  4  brightness, duty = cfg_duty/16.
REQ-012 Port led  output  N_CH  registered LED drive, 1 = lit.
REQ-013 Port busy  output  N_CH  channel in PULSE mode and not yet expired.

Function
REQ-014 Prescaler SHALL count 0..TICK_DIV-1 and assert an internal one-cycle tick on terminal count, then wrap to 0.
REQ-015 A write SHALL be accepted on a rising edge where cfg_valid and cfg_ready are both 1.
REQ-016 cfg_ready SHALL be 0 for exactly the one cycle following an acceptance, and 1 otherwise outside reset.
REQ-017 On acceptance, channel cfg_ch SHALL load mode, period and duty, and clear its tick counter.
REQ-018 cfg_ch >= N_CH SHALL complete the handshake with no state change.
REQ-019 cfg_period 0 SHALL be treated as 1.
REQ-020 OFF: led bit 0; ON: led bit 1 (subject to REQ-030).
REQ-021 BLINK: phase SHALL start at 1 on acceptance and toggle after every period ticks; led bit = phase.
REQ-022 PULSE: led bit and busy bit SHALL be 1 for period ticks, then the channel SHALL switch to OFF and clear busy.
REQ-023 The new mode SHALL appear on led one cycle after the accepting edge; tick-driven changes appear one cycle after the tick.
REQ-024 A write and a tick on the same channel in the same cycle: the write SHALL win and that tick SHALL NOT be counted for the channel.
REQ-025 Rewriting a channel mid-BLINK or mid-PULSE SHALL restart it from REQ-021/REQ-022 start conditions.
REQ-026 Per-channel tick counter SHALL be PER_W bits and never wrap past period.

Reset
REQ-027 While rst_n=0: led=0, busy=0, cfg_ready=0, all channels OFF, period 1, duty 15, prescaler and tick counters 0.
REQ-028 cfg_ready SHALL rise on the first rising edge after rst_n deasserts; reset mid-pulse SHALL abort the pulse immediately.

Configuration
REQ-029 Macro LED_PATTERN_PWM_EN SHALL select brightness control.
REQ-030 With LED_PATTERN_PWM_EN: a free-running 4-bit PWM counter SHALL gate each lit led bit, on while counter < duty; duty 0 = always dark.
REQ-031 Without LED_PATTERN_PWM_EN: cfg_duty SHALL be ignored and lit bits are steady 1; port list is unchanged.

Structure
REQ-032 Package led_pkg SHALL hold the 2-bit mode enum (OFF/ON/BLINK/PULSE) and the PWM counter width constant.
REQ-033 The prescaler SHALL be sub-module led_tick_prescaler (params TICK_DIV; ports clk_in, rst_n, tick).

Verification (TICK_DIV=4, N_CH=4, PER_W=4)
REQ-034 Reset: rst_n=0 mid-run -> led=0, busy=0, cfg_ready=0 immediately; cfg_ready=1 one edge after release.
REQ-035 Write ch1 BLINK period 2 -> led[1]=1 next cycle, toggles every 8 cycles, other channels stay 0.
REQ-036 Write ch2 PULSE period 3 -> led[2]=busy[2]=1 for 12 cycles (+/- tick alignment, counter cleared), then both 0 and mode OFF.
REQ-037 Back-to-back cfg_valid held 2 cycles -> only first accepted, cfg_ready=0 second cycle, second write accepted third cycle.
REQ-038 Write ch7 ON -> handshake completes, led unchanged; write coinciding with tick on ch1 -> ch1 counter restarts at 0.
REQ-039 PWM build, ch0 ON duty 4 -> led[0] high 4 of every 16 cycles; non-PWM build -> steady 1.
